// File: rtl/spi_sd_pkg.sv
// Shared SD-card SPI definitions: response types, transmitter states and
// response framing constants used by both the command and response paths.
package spi_sd_pkg;

    typedef enum logic [1:0] {
        RESP_R1  = 2'd0,
        RESP_R3  = 2'd1,
        RESP_R7  = 2'd2,
        RESP_R1B = 2'd3
    } resp_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NCR  = 2'd1,
        SEND = 2'd2,
        BUSY = 2'd3
    } tx_state_e;

    localparam logic [7:0] FILL_BYTE       = 8'hFF;
    localparam int         RESP_BITS_SHORT = 8;
    localparam int         RESP_BITS_LONG  = 40;

    // R3 and R7 carry a 32-bit word after the R1 byte.
    function automatic logic is_long_resp(resp_type_e t);
        return (t == RESP_R3) || (t == RESP_R7);
    endfunction

endpackage

// File: rtl/spi_sck_edge_detect.sv
// Detects SCK edges in the system clock domain; SCK is already synchronous
// to clock, so a single history register is enough.
module spi_sck_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic sck,
    output logic fall,
    output logic rise
);

    logic sck_q;

    // NOTE: state registers use non-blocking assignment so every flop
    // samples the pre-edge value of its inputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) sck_q <= 1'b0;
        else       sck_q <= sck;
    end

    assign fall = sck_q & ~sck;
    assign rise = ~sck_q & sck;

endmodule

// File: rtl/spi_response_transmitter.sv
// SD-card MISO response serializer: NCR filler, R1/R3/R7 token and R1b busy
// phase, shifted out MSB-first on SCK falling edges (SPI mode 0).
module spi_response_transmitter
    import spi_sd_pkg::*;
#(
    parameter int NCR_BYTES  = 1,
    parameter int BUSY_BYTES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_SCK,
    input  logic        io_CS,
    input  logic        io_Start,
    input  logic [1:0]  io_ResponseType,
    input  logic [7:0]  io_R1,
    input  logic [31:0] io_Payload,
    output logic        io_DO,
    output logic        io_Ready,
    output logic        io_Done,
    output logic        io_Aborted
);

    localparam logic [7:0] NCR_LAST_BYTE  = 8'(NCR_BYTES - 1);
    localparam logic [7:0] BUSY_LAST_BYTE = 8'(BUSY_BYTES - 1);
    localparam logic [7:0] LONG_LAST_BYTE = 8'(RESP_BITS_LONG / 8 - 1);

    tx_state_e   state_q, state_d;
    resp_type_e  type_q, type_d;
    logic [39:0] shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;
    logic        sck_fall;
    logic        sck_rise;
    logic        last_bit;

    spi_sck_edge_detect u_sck_edge (
        .clock (clock),
        .reset (reset),
        .sck   (io_SCK),
        .fall  (sck_fall),
        .rise  (sck_rise)
    );

    assign last_bit = (bit_cnt_q == 3'd0) && (byte_cnt_q == 8'd0);

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through the
        // case can leave a signal unassigned and infer a latch.
        state_d    = state_q;
        type_d     = type_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;

        if (state_q == IDLE) begin
            if (io_Start && !io_CS) begin
                type_d     = resp_type_e'(io_ResponseType);
                shift_d    = is_long_resp(resp_type_e'(io_ResponseType))
                             ? {io_R1, io_Payload} : {io_R1, {4{FILL_BYTE}}};
                bit_cnt_d  = 3'd7;
                byte_cnt_d = NCR_LAST_BYTE;
                state_d    = NCR;
            end
        end else if (io_CS) begin
            // Host dropped the transfer; abort wins over any pending edge.
            state_d = IDLE;
            abort_d = 1'b1;
        end else if (sck_fall) begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) byte_cnt_d = byte_cnt_q - 8'd1;
            if (state_q == SEND) shift_d = {shift_q[38:0], 1'b1};

            if (last_bit) begin
                bit_cnt_d = 3'd7;
                unique case (state_q)
                    NCR: begin
                        state_d    = SEND;
                        byte_cnt_d = is_long_resp(type_q) ? LONG_LAST_BYTE : 8'd0;
                    end
                    SEND: begin
                        if (type_q == RESP_R1B) begin
                            state_d    = BUSY;
                            byte_cnt_d = BUSY_LAST_BYTE;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                    BUSY: begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            type_q     <= RESP_R1;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    always_comb begin
        unique case (state_q)
            SEND:    io_DO = shift_q[39];
            BUSY:    io_DO = 1'b0;
            default: io_DO = 1'b1;
        endcase
    end

    assign io_Ready   = (state_q == IDLE);
    assign io_Done    = done_q;
    assign io_Aborted = abort_q;

endmodule
